cr_xp10_decomp_be_ob_sched: RTL

// - Output scheduler for the XP10 decompressor back end.
// - Shares one TLV output write port between two FIFO-style TLV sources:
//   - the pass-through (PT) TLV stream;
//   - the LZ decompressed-data TLV stream.
// - Arbitrates only at whole-TLV boundaries (sot..eot); a TLV is never interleaved.
// - Drives the user write port of the TLV reassembly stage ahead of the AXI4-S master.
// - Monitors stalls inside a TLV.

---
 rtl/cr_xp10_decomp_be_ob_sched.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/cr_xp10_decomp_be_ob_sched.sv
// Purpose : XP10 decompressor back-end output scheduler. Shares one TLV write
//           port between the pass-through (PT) and LZ TLV sources, switching
//           only at whole-TLV boundaries, and watches for mid-TLV starvation.
// Latency : 1 cycle from source pop to ob_wr; one IDLE decision cycle per TLV.
// Backpr. : pops are gated by ob_afull sampled at pop time; the downstream
//           guarantees >= 2 free entries while ob_afull is low.
// Ports   : clk, rst (async, active high); cfg_pt_prio (1 = strict PT priority,
//           0 = round-robin); pt_empty/pt_tlv/pt_rd and lz_empty/lz_tlv/lz_rd
//           are the FIFO-style source heads; ob_afull/ob_wr/ob_tlv form the
//           downstream write port; busy = FSM not IDLE; stall_err is sticky.
// TLV word layout (TLVP_W bits): [TLVP_W-1] sot, [TLVP_W-2] eot, rest payload.
module cr_xp10_decomp_be_ob_sched #(
  parameter int STALL_LIMIT = 1024,
  parameter int STALL_CW    = 11,
  parameter int TLVP_W      = 66
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_pt_prio,
  input  logic              pt_empty,
  input  logic [TLVP_W-1:0] pt_tlv,
  output logic              pt_rd,
  input  logic              lz_empty,
  input  logic [TLVP_W-1:0] lz_tlv,
  output logic              lz_rd,
  input  logic              ob_afull,
  output logic              ob_wr,
  output logic [TLVP_W-1:0] ob_tlv,
  output logic              busy,
  output logic              stall_err
);

  localparam int SOT_BIT = TLVP_W - 1;
  localparam int EOT_BIT = TLVP_W - 2;
  localparam logic [STALL_CW-1:0] LIMIT    = STALL_CW'(STALL_LIMIT);
  localparam logic [STALL_CW-1:0] LIMIT_M1 = STALL_CW'(STALL_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PT_XFER = 2'd1,
    LZ_XFER = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_lz;     // 1 = most recent completed TLV came from LZ
  logic                r_started;     // granted source has delivered a word of this TLV
  logic [STALL_CW-1:0] r_stall_cnt;
  logic                r_stall_err;
  logic                r_ob_wr;
  logic [TLVP_W-1:0]   r_ob_tlv;

  logic                w_pop;
  logic [TLVP_W-1:0]   w_pop_tlv;
  logic                w_pop_eot;
  logic                w_gnt_empty;
  logic                w_stall_tick;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. The grant is registered, so the IDLE cycle never pops.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!pt_empty && !lz_empty) begin
          // Round-robin goes opposite the last grant; priority mode always PT.
          w_state_nxt = (cfg_pt_prio || r_last_lz) ? PT_XFER : LZ_XFER;
        end else if (!pt_empty) begin
          w_state_nxt = PT_XFER;
        end else if (!lz_empty) begin
          w_state_nxt = LZ_XFER;
        end
      end
      PT_XFER: if (pt_rd && pt_tlv[EOT_BIT]) w_state_nxt = IDLE;
      LZ_XFER: if (lz_rd && lz_tlv[EOT_BIT]) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Only the granted source can ever be popped.
  // ---------------------------------------------------------------------------
  always_comb begin
    pt_rd = (r_state == PT_XFER) && !pt_empty && !ob_afull;
    lz_rd = (r_state == LZ_XFER) && !lz_empty && !ob_afull;
    busy  = (r_state != IDLE);
  end

  assign w_pop       = pt_rd | lz_rd;
  assign w_pop_tlv   = pt_rd ? pt_tlv : lz_tlv;
  assign w_pop_eot   = w_pop && w_pop_tlv[EOT_BIT];
  assign w_gnt_empty = ((r_state == PT_XFER) && pt_empty) ||
                       ((r_state == LZ_XFER) && lz_empty);
  // Throttling by ob_afull leaves the source non-empty, so it never ticks here.
  assign w_stall_tick = r_started && w_gnt_empty;

  // ---------------------------------------------------------------------------
  // Grant history and per-TLV progress
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_lz <= 1'b1;   // first round-robin pick after reset is PT
      r_started <= 1'b0;
    end else begin
      if (w_pop_eot) begin
        r_last_lz <= lz_rd;
      end
      if (w_pop_eot || r_state == IDLE) begin
        r_started <= 1'b0;
      end else if (w_pop) begin
        r_started <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mid-TLV stall monitor: saturating counter, sticky error, never aborts.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
    end else begin
      if (w_pop || r_state == IDLE) begin
        r_stall_cnt <= '0;
      end else if (w_stall_tick && r_stall_cnt != LIMIT) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_stall_tick && !w_pop && r_stall_cnt == LIMIT_M1) begin
        r_stall_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register stage; ob_tlv holds its last value between writes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ob_wr  <= 1'b0;
      r_ob_tlv <= '0;
    end else begin
      r_ob_wr <= w_pop;
      if (w_pop) begin
        r_ob_tlv <= w_pop_tlv;
      end
    end
  end

  assign ob_wr     = r_ob_wr;
  assign ob_tlv    = r_ob_tlv;
  assign stall_err = r_stall_err;

  // The first word taken from a source in a transfer must open a TLV. The
  // word is forwarded regardless; this only flags a malformed source.
  a_first_pop_sot: assert property (@(posedge clk) disable iff (rst)
    (w_pop && !r_started) |-> w_pop_tlv[SOT_BIT]);

  a_rd_onehot: assert property (@(posedge clk) disable iff (rst)
    !(pt_rd && lz_rd));

endmodule
